// File: rtl/ann_pkg.sv
// Shared ANN layer definitions: weight BRAM geometry and the
// weight sequencer FSM encoding.
package ann_pkg;

  localparam int WEIGHT_DEPTH  = 28;
  localparam int WEIGHT_ADDR_W = 5;
  localparam int WEIGHT_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } wseq_state_e;

endpackage

// File: rtl/weight_bram_sequencer.sv
// Single-port weight BRAM arbiter: host writes vs. MAC read stream.
// Define WSEQ_STALL_EN to add W_READY backpressure on the stream.
module weight_bram_sequencer
  import ann_pkg::*;
#(
  parameter int DEPTH  = WEIGHT_DEPTH,
  parameter int ADDR_W = WEIGHT_ADDR_W,
  parameter int DATA_W = WEIGHT_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_REQ,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_GNT,
  input  logic              RD_START,
  output logic              RD_BUSY,
`ifdef WSEQ_STALL_EN
  input  logic              W_READY,
`endif
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  output logic [ADDR_W-1:0] W_INDEX,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] BR_ADDR,
  output logic [DATA_W-1:0] BR_DI,
  output logic              BR_EN,
  output logic              BR_WE,
  input  logic [DATA_W-1:0] BR_DO
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  wseq_state_e state_q, state_d;
  logic pend_q, pend_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic vld_q, vld_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic w_ready;
  logic more;
  logic adv;
  logic issue;
  logic wr_ok;

`ifdef WSEQ_STALL_EN
  assign w_ready = W_READY;
`else
  assign w_ready = 1'b1;
`endif

  // adv: the output slot is free or being consumed this cycle
  assign more  = iss_q < DEPTH_C;
  assign adv   = !vld_q || w_ready;
  assign issue = (state_q == ST_READ) && more && adv;
  assign wr_ok = (state_q == ST_WRITE)
              && ({1'b0, LD_ADDR} < DEPTH_C);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    iss_d   = iss_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (LD_REQ) begin
          state_d = ST_WRITE;
          if (RD_START) pend_d = 1'b1;
        end else if (RD_START || pend_q) begin
          state_d = ST_READ;
          pend_d  = 1'b0;
          iss_d   = '0;
          vld_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (RD_START) pend_d = 1'b1;
      end
      ST_READ: begin
        if (RD_START) pend_d = 1'b1;
        if (issue) begin
          vld_d = 1'b1;
          idx_d = iss_q[ADDR_W-1:0];
          iss_d = iss_q + ONE_C;
        end else if (adv) begin
          vld_d = 1'b0;
          if (!more) begin
            state_d = ST_IDLE;
            iss_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      iss_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      iss_q   <= iss_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  assign LD_GNT  = (state_q == ST_WRITE);
  assign RD_BUSY = (state_q == ST_READ);

  // Idle port is driven to all-zero so the BRAM sees no stray address
  assign BR_EN   = wr_ok || issue;
  assign BR_WE   = wr_ok;
  assign BR_ADDR = wr_ok ? LD_ADDR
                 : issue ? iss_q[ADDR_W-1:0]
                 : '0;
  assign BR_DI   = wr_ok ? LD_DATA : '0;

  assign W_VALID = vld_q;
  assign W_INDEX = idx_q;
  assign W_DATA  = vld_q ? BR_DO : '0;
  assign W_LAST  = vld_q && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a falling-edge BRAM model.
// Stall scenario is built only when WSEQ_STALL_EN is defined.
module tb_weight_bram_sequencer;

  localparam int DEPTH = 28;

  logic        CLK;
  logic        RST;
  logic        LD_REQ;
  logic [4:0]  LD_ADDR;
  logic [15:0] LD_DATA;
  logic        LD_GNT;
  logic        RD_START;
  logic        RD_BUSY;
`ifdef WSEQ_STALL_EN
  logic        W_READY;
`endif
  logic        W_VALID;
  logic [15:0] W_DATA;
  logic [4:0]  W_INDEX;
  logic        W_LAST;
  logic [4:0]  BR_ADDR;
  logic [15:0] BR_DI;
  logic        BR_EN;
  logic        BR_WE;
  logic [15:0] BR_DO;

  logic [15:0] mem [0:31];
  logic [15:0] refw [0:DEPTH-1];
  int checks;
  int failures;

  weight_bram_sequencer dut (
    .CLK      (CLK),
    .RST      (RST),
    .LD_REQ   (LD_REQ),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .LD_GNT   (LD_GNT),
    .RD_START (RD_START),
    .RD_BUSY  (RD_BUSY),
`ifdef WSEQ_STALL_EN
    .W_READY  (W_READY),
`endif
    .W_VALID  (W_VALID),
    .W_DATA   (W_DATA),
    .W_INDEX  (W_INDEX),
    .W_LAST   (W_LAST),
    .BR_ADDR  (BR_ADDR),
    .BR_DI    (BR_DI),
    .BR_EN    (BR_EN),
    .BR_WE    (BR_WE),
    .BR_DO    (BR_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BR_EN) begin
      if (BR_WE) mem[BR_ADDR] <= BR_DI;
      else BR_DO <= mem[BR_ADDR];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ld(input logic [4:0] a, input logic [15:0] d);
    logic ok;
    ok = (a < 5'd28);
    LD_REQ  = 1'b1;
    LD_ADDR = a;
    LD_DATA = d;
    tick();
    chk("ld_gnt", {LD_GNT, BR_EN, BR_WE, BR_ADDR, BR_DI},
        {1'b1, ok, ok, ok ? a : 5'd0, ok ? d : 16'd0});
    LD_REQ = 1'b0;
    if (ok) refw[a] = d;
    tick();
    chk("ld_pulse", {LD_GNT, BR_EN}, 2'b00);
  endtask

  task automatic start_rd();
    RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
    chk("issue0", {RD_BUSY, BR_EN, BR_WE, BR_ADDR}, {3'b110, 5'd0});
  endtask

  task automatic expect_stream(input string tag, input int exp_wait);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!W_VALID && n < 16);
    chk({tag, "_lat"}, n, exp_wait);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) tick();
      chk({tag, "_w"}, {W_VALID, W_LAST, W_INDEX, W_DATA},
          {1'b1, 1'(i == DEPTH - 1), 5'(i), refw[i]});
    end
    tick();
    chk({tag, "_end"}, {RD_BUSY, W_VALID}, 2'b00);
  endtask

  task automatic quiet(input string tag);
    int cnt;
    cnt = 0;
    repeat (40) begin
      tick();
      if (W_VALID || RD_BUSY) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (RD_BUSY && n < 60) begin
      tick();
      n++;
    end
    chk(tag, RD_BUSY, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int gnt;
    int n;
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    LD_REQ   = 1'b0;
    LD_ADDR  = '0;
    LD_DATA  = '0;
    RD_START = 1'b0;
`ifdef WSEQ_STALL_EN
    W_READY  = 1'b1;
`endif
    tick();
    tick();
    chk("reset", {LD_GNT, RD_BUSY, W_VALID, W_LAST, W_INDEX,
                  BR_EN, BR_WE, BR_ADDR}, 0);
    chk("reset_di", BR_DI, 0);
    RST = 1'b0;
    tick();

    // single write, then preload everything else with i+100
    ld(5'd3, 16'h00A5);
    for (int i = 0; i < DEPTH; i++)
      if (i != 3) ld(5'(i), 16'(i + 100));
    ld(5'd30, 16'hFFFF);
    start_rd();
    expect_stream("s_a5", 1);

    ld(5'd3, 16'd103);
    start_rd();
    expect_stream("s_full", 1);

    // write and start in the same IDLE cycle
    LD_REQ   = 1'b1;
    LD_ADDR  = 5'd5;
    LD_DATA  = 16'h1234;
    RD_START = 1'b1;
    tick();
    chk("same_gnt", {LD_GNT, RD_BUSY, BR_WE, BR_ADDR}, {3'b101, 5'd5});
    LD_REQ   = 1'b0;
    RD_START = 1'b0;
    refw[5]  = 16'h1234;
    tick();
    chk("same_gap", {RD_BUSY, LD_GNT}, 2'b00);
    tick();
    chk("same_iss", {RD_BUSY, BR_EN, BR_ADDR}, {2'b11, 5'd0});
    expect_stream("s_same", 1);

    // loader and second start arriving mid-stream
    start_rd();
    repeat (5) tick();
    LD_REQ   = 1'b1;
    LD_ADDR  = 5'd7;
    LD_DATA  = 16'hBEEF;
    RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
    gnt = 0;
    n = 0;
    while (RD_BUSY && n < 60) begin
      if (LD_GNT) gnt++;
      tick();
      n++;
    end
    chk("gnt_in_read", gnt, 0);
    chk("mid_idle", {RD_BUSY, LD_GNT}, 2'b00);
    tick();
    chk("mid_gnt", {LD_GNT, BR_WE, BR_ADDR, BR_DI},
        {2'b11, 5'd7, 16'hBEEF});
    LD_REQ  = 1'b0;
    refw[7] = 16'hBEEF;
    tick();
    chk("mid_gap", RD_BUSY, 0);
    tick();
    chk("mid_iss", {RD_BUSY, BR_EN, BR_ADDR}, {2'b11, 5'd0});
    expect_stream("s_follow", 1);
    quiet("one_follow");

    // back-to-back: extra start while pending is dropped
    start_rd();
    repeat (3) tick();
    RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
    tick();
    RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
    wait_idle("b2b_fall");
    tick();
    chk("b2b_iss", {RD_BUSY, BR_EN, BR_ADDR}, {2'b11, 5'd0});
    expect_stream("s_b2b", 1);
    quiet("b2b_single");

    // asynchronous reset in the middle of a stream
    start_rd();
    n = 0;
    do begin
      tick();
      n++;
    end while (!(W_VALID && W_INDEX == 5'd10) && n < 40);
    chk("reach10", {W_VALID, W_INDEX}, {1'b1, 5'd10});
    #2 RST = 1'b1;
    #1;
    chk("rst_async", {W_VALID, RD_BUSY, LD_GNT, BR_EN, BR_WE,
                      W_LAST, W_INDEX, BR_ADDR}, 0);
    chk("rst_data", {W_DATA, BR_DI}, 0);
    tick();
    RST = 1'b0;
    quiet("rst_quiet");
    start_rd();
    expect_stream("s_rst", 1);

`ifdef WSEQ_STALL_EN
    start_rd();
    n = 0;
    do begin
      tick();
      n++;
    end while (!(W_VALID && W_INDEX == 5'd7) && n < 40);
    W_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", {W_VALID, BR_EN, W_INDEX, W_DATA},
          {2'b10, 5'd7, refw[7]});
      tick();
    end
    W_READY = 1'b1;
    for (int i = 7; i < DEPTH; i++) begin
      chk("stall_w", {W_VALID, W_LAST, W_INDEX, W_DATA},
          {1'b1, 1'(i == DEPTH - 1), 5'(i), refw[i]});
      tick();
    end
    chk("stall_end", {RD_BUSY, W_VALID}, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
